matrix_rotator: RTL and testbench

Parametrised, registered successor to the team's combinational 4x4 byte crisscross permuter. Accepts an N x N matrix of DW-bit elements over a valid/ready handshake and applies a selected permutation a programmable number of times, one step per clock. Presents the result on a held valid/ready output. Sits in the cipher datapath between the key-mixing stage and the substitution stage, replacing the fixed right/left crisscross.

---
 rtl/matrix_rotator.sv | 119 +++++++++++
 tb/tb_matrix_rotator.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/matrix_rotator.sv
// matrix_rotator: registered N x N matrix permuter for the cipher datapath.
// Takes a matrix over valid/ready, applies the selected permutation `steps`
// times (one application per clock) and holds the result until it is taken.
// Build option: define MATRIX_ROTATOR_SHIFTROWS_EN to make mode 11 shift-rows
// (out(r,c) = in(r,(c+r) mod N)); otherwise mode 11 is rotate-180.
module matrix_rotator #(
    parameter int DW = 8,
    parameter int N  = 4,
    parameter int SW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*N*DW-1:0] in_mat,
    input  logic [1:0]        mode,
    input  logic [SW-1:0]     steps,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*N*DW-1:0] out_mat,
    output logic              busy
);

    localparam int MW = N * N * DW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [MW-1:0] r_mat;
    logic [1:0]    r_mode;
    logic [SW-1:0] r_cnt;
    logic [MW-1:0] w_perm;

    // One application of the selected permutation; each output element
    // picks its source element by (row, column) index arithmetic.
    function automatic logic [MW-1:0] f_permute(input logic [MW-1:0] m,
                                                input logic [1:0]    md);
        logic [MW-1:0] res;
        int sr;
        int sc;
        res = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                case (md)
                    2'b00: begin sr = N - 1 - c; sc = r;         end
                    2'b01: begin sr = c;         sc = N - 1 - r; end
                    2'b10: begin sr = c;         sc = r;         end
                    default: begin
`ifdef MATRIX_ROTATOR_SHIFTROWS_EN
                        sr = r;
                        sc = (c + r) % N;
`else
                        sr = N - 1 - r;
                        sc = N - 1 - c;
`endif
                    end
                endcase
                res[(r*N+c)*DW +: DW] = m[(sr*N+sc)*DW +: DW];
            end
        end
        return res;
    endfunction

    // Next matrix value while stepping, using the mode latched at accept.
    always_comb begin
        w_perm = f_permute(r_mat, r_mode);
    end

    // Control FSM and step counter; a new job is accepted only from IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mode  <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mode  <= mode;
                        r_cnt   <= steps;
                        r_state <= (steps == '0) ? S_DONE : S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - SW'(1);
                    if (r_cnt == SW'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Matrix state register: loaded at accept, permuted once per BUSY cycle,
    // held otherwise so the result is stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mat <= '0;
        end else if (r_state == S_IDLE && in_valid) begin
            r_mat <= in_mat;
        end else if (r_state == S_BUSY) begin
            r_mat <= w_perm;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_BUSY) || (r_state == S_DONE);
    assign out_mat   = r_mat;

endmodule

// File: tb/tb_matrix_rotator.sv
// Directed bench for matrix_rotator (N=4, DW=8, SW=4).
// Input element (r,c) = {r,c} nibbles; rows compared as {c0,c1,c2,c3}.
module tb_matrix_rotator;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_mat;
    logic [1:0]   mode;
    logic [3:0]   steps;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_mat;
    logic         busy;

    int checks;
    int failures;
    int busy_cnt;
    int ov_seen;

    matrix_rotator #(.DW(8), .N(4), .SW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mat   (in_mat),
        .mode     (mode),
        .steps    (steps),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_mat  (out_mat),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] row(input int r);
        logic [31:0] v;
        for (int c = 0; c < 4; c++) begin
            v[(3-c)*8 +: 8] = out_mat[(r*4+c)*8 +: 8];
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [1:0] md, input logic [3:0] st);
        mode     = md;
        steps    = st;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        mode     = 2'b11;
        steps    = 4'hf;
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [127:0] base;

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mode      = 2'b00;
        steps     = 4'd0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                base[(r*4+c)*8 +: 8] = 8'(r*16 + c);
            end
        end
        in_mat = base;
        tick();
        tick();
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_out_mat", out_mat, 128'd0);
        rst = 1'b0;
        tick();

        // Rotate right, one step
        accept(2'b00, 4'd1);
        chk("rr1_lat0_valid", 128'(out_valid), 128'd0);
        chk("rr1_lat0_busy", 128'(busy), 128'd1);
        tick();
        chk("rr1_valid", 128'(out_valid), 128'd1);
        chk("rr1_row0", 128'(row(0)), 128'(32'h30201000));
        chk("rr1_row3", 128'(row(3)), 128'(32'h33231303));
        take();
        chk("rr1_in_ready_after", 128'(in_ready), 128'd1);

        // Rotate left, four steps, out_ready tied high
        accept(2'b01, 4'd4);
        out_ready = 1'b1;
        busy_cnt  = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) busy_cnt++;
            if (i == 3) chk("rl4_lat3_valid", 128'(out_valid), 128'd0);
            if (i == 4) begin
                chk("rl4_valid", 128'(out_valid), 128'd1);
                chk("rl4_identity", out_mat, base);
            end
            tick();
        end
        out_ready = 1'b0;
        chk("rl4_busy_cycles", 128'(busy_cnt), 128'd5);

        // Transpose, zero steps: pass-through
        accept(2'b10, 4'd0);
        chk("tr0_valid", 128'(out_valid), 128'd1);
        chk("tr0_pass", out_mat, base);
        take();

        // Transpose, three steps
        accept(2'b10, 4'd3);
        tick();
        tick();
        chk("tr3_lat2_valid", 128'(out_valid), 128'd0);
        tick();
        chk("tr3_valid", 128'(out_valid), 128'd1);
        chk("tr3_row0", 128'(row(0)), 128'(32'h00102030));
        take();

        // Rotate right twice under backpressure; second request ignored
        accept(2'b00, 4'd2);
        tick();
        tick();
        chk("bp_valid_start", 128'(out_valid), 128'd1);
        chk("bp_row0_start", 128'(row(0)), 128'(32'h33323130));
        in_valid = 1'b1;
        mode     = 2'b10;
        steps    = 4'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("bp_in_ready_low", 128'(in_ready), 128'd0);
        end
        in_valid = 1'b0;
        chk("bp_valid_hold", 128'(out_valid), 128'd1);
        chk("bp_row0_hold", 128'(row(0)), 128'(32'h33323130));
        take();
        chk("bp_in_ready_release", 128'(in_ready), 128'd1);
        chk("bp_no_second_job", 128'(out_valid), 128'd0);

        // Fifteen steps interrupted by reset in the fifth BUSY cycle
        accept(2'b00, 4'd15);
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_in_ready", 128'(in_ready), 128'd1);
        chk("rst_mid_out_valid", 128'(out_valid), 128'd0);
        chk("rst_mid_busy", 128'(busy), 128'd0);
        chk("rst_mid_out_mat", out_mat, 128'd0);
        tick();
        rst = 1'b0;
        ov_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) ov_seen++;
        end
        chk("rst_no_out_valid", 128'(ov_seen), 128'd0);
        accept(2'b10, 4'd1);
        tick();
        chk("post_rst_valid", 128'(out_valid), 128'd1);
        chk("post_rst_row1", 128'(row(1)), 128'(32'h01112131));
        take();

        // Full fifteen steps: rotate right x15 == rotate left
        accept(2'b00, 4'd15);
        for (int i = 0; i < 14; i++) tick();
        chk("rr15_lat14_valid", 128'(out_valid), 128'd0);
        tick();
        chk("rr15_valid", 128'(out_valid), 128'd1);
        chk("rr15_row0", 128'(row(0)), 128'(32'h03132333));
        take();

        // Mode 11, one step
        accept(2'b11, 4'd1);
        tick();
        chk("m11_valid", 128'(out_valid), 128'd1);
`ifdef MATRIX_ROTATOR_SHIFTROWS_EN
        chk("m11_shiftrows_row1", 128'(row(1)), 128'(32'h11121310));
`else
        chk("m11_rot180_row0", 128'(row(0)), 128'(32'h33323130));
`endif
        take();
        chk("final_in_ready", 128'(in_ready), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
